rect_plotter: RTL and testbench
===============================

// Module: rect_plotter
// PURPOSE
//   Rectangle fill engine between the game control FSM and vga_adapter.
//   Accepts one rectangle command per handshake: draw, erase, or full-screen clear.
//   Streams one pixel per clock onto the adapter's x/y/colour/plot inputs.
//   Replaces the per-state draw_counter loops in the game FSM with a single clipped raster walker.
// PARAMETERS
//   SCREEN_W   160  visible width in pixels; pixels with x >= SCREEN_W are clipped
//   SCREEN_H   120  visible height in pixels; pixels with y >= SCREEN_H are clipped
//   COORD_W    8    width of x/y coordinates and of rectangle dimensions
//   COLOUR_W   3    colour width (1 bit per channel)
// PORTS
//   clock       in   1         system clock (CLOCK_50)
//   resetn      in   1         synchronous reset, active-low
//   req_valid   in   1         command valid
//   req_ready   out  1         engine idle, command accepted when valid&ready
//   req_x0      in   COORD_W   top-left x
//   req_y0      in   COORD_W   top-left y
//   req_w       in   COORD_W   width in pixels (0 = empty)
//   req_h       in   COORD_W   height in pixels (0 = empty)
//   req_colour  in   COLOUR_W  fill colour (000 = erase)
//   req_clear   in   1         1 = fill whole screen; x0/y0/w/h ignored
//   x           out  COORD_W   pixel x to vga_adapter
//   y           out  COORD_W   pixel y to vga_adapter
//   colour      out  COLOUR_W  pixel colour to vga_adapter
//   plot        out  1         pixel write strobe to vga_adapter
//   busy        out  1         high in RUN and DONE
//   done        out  1         one-cycle pulse after the last pixel of a command
// BEHAVIOUR
//   All outputs are registered.
//   Reset (resetn=0 at a clock edge):
//     state=IDLE; x=y=colour=0; plot=0; busy=0; done=0.
//     req_ready=1 in the first cycle after reset is released.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     req_ready=1.
//     On valid&ready, latch x0/y0/colour and w/h.
//       req_clear forces x0=0, y0=0, w=SCREEN_W, h=SCREEN_H.
//     Zero-size command (w==0 or h==0): go to DONE; no pixel is emitted.
//     Otherwise: col=0, row=0, go to RUN.
//   RUN:
//     req_ready=0; req_valid is ignored and no command is queued.
//     Each cycle, register ax=x0+col and ay=y0+row, both computed in COORD_W+1 bits (no wrap).
//     plot=1 only if ax<SCREEN_W and ay<SCREEN_H.
//     When plot=1, x=ax[COORD_W-1:0], y=ay, colour=latched colour.
//     When plot=0, x=y=colour=0.
//     Raster order: col increments first; at col==w-1, col=0 and row++.
//     Clipped pixels still consume a cycle. A command always takes exactly w*h RUN cycles.
//     At col==w-1 and row==h-1, go to DONE.
//   DONE:
//     done=1 and busy=1 for exactly one cycle; plot=0.
//     Next state is IDLE, so req_ready returns 1 the following cycle.
//   Timing:
//     Command accepted at edge N -> first pixel valid in the cycle after edge N.
//     Last pixel in cycle N+w*h; done in cycle N+w*h+1; req_ready=1 in cycle N+w*h+2.
//     Minimum command spacing is w*h+2 cycles.
//   Reset mid-RUN: aborts the command. plot=0 and done=0 from the next cycle; the remaining pixels are never emitted.
//   The latched command is immune to input changes after acceptance.
// TESTING
//   T1 reset: resetn=0 for 2 cycles, then 1 -> req_ready=1, plot=0, busy=0, done=0, x=y=colour=0.
//   T2 paddle: x0=30 y0=100 w=16 h=2 colour=111
//      -> 32 plot cycles, in order (30,100)..(45,100),(30,101)..(45,101)
//      -> done pulse on cycle 33; req_ready=1 on cycle 34.
//   T3 clip: x0=150 y0=118 w=16 h=4 colour=110
//      -> 64 RUN cycles, exactly 20 plots (x 150..159, y 118..119), never x>=160 or y>=120
//      -> done on cycle 65.
//   T4 clear: req_clear=1 colour=000 -> 19200 consecutive plots, first (0,0), last (159,119); done on cycle 19201.
//   T5 empty/backpressure: w=0 h=5 -> no plot, done in the cycle after accept.
//      Then issue a command; assert req_valid with a second command mid-RUN -> it is not accepted until req_ready=1.
//   T6 abort: x0=40 y0=40 w=8 h=8; drop resetn after 5 pixels
//      -> plot=0 next cycle; no done pulse; req_ready=1 after resetn=1.

Source files
------------

// File: rtl/rect_plotter.sv
// rect_plotter
//   Rectangle fill engine sitting between the game control FSM and
//   vga_adapter. Accepts one command per valid/ready handshake (draw,
//   erase with colour 000, or full-screen clear) and walks the rectangle
//   in raster order, one pixel per clock, clipping anything off-screen.
//
// Ports
//   clock       system clock (CLOCK_50)
//   resetn      synchronous reset, active-low
//   req_valid   command valid
//   req_ready   engine idle; command taken when req_valid & req_ready
//   req_x0/y0   top-left corner
//   req_w/h     size in pixels (0 = empty command)
//   req_colour  fill colour
//   req_clear   fill the whole screen, geometry inputs ignored
//   x/y/colour  pixel to vga_adapter (zero when plot is low)
//   plot        pixel write strobe
//   busy        command in progress (RUN or DONE)
//   done        one-cycle pulse after the last pixel of a command
module rect_plotter #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COORD_W-1:0]  req_x0,
  input  logic [COORD_W-1:0]  req_y0,
  input  logic [COORD_W-1:0]  req_w,
  input  logic [COORD_W-1:0]  req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  input  logic                req_clear,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [COORD_W:0] LIM_X = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] LIM_Y = (COORD_W+1)'(SCREEN_H);

  state_t state;

  logic [COORD_W-1:0]  x0_q, y0_q, w_q, h_q;
  logic [COORD_W-1:0]  col_q, row_q;
  logic [COLOUR_W-1:0] colour_q;

  // Effective command after applying the clear override
  logic [COORD_W-1:0] cmd_x0, cmd_y0, cmd_w, cmd_h;

  always_comb begin
    if (req_clear) begin
      cmd_x0 = '0;
      cmd_y0 = '0;
      cmd_w  = COORD_W'(SCREEN_W);
      cmd_h  = COORD_W'(SCREEN_H);
    end else begin
      cmd_x0 = req_x0;
      cmd_y0 = req_y0;
      cmd_w  = req_w;
      cmd_h  = req_h;
    end
  end

  logic accept;
  logic cmd_empty;
  logic col_last;
  logic last_px;

  assign accept    = req_valid & req_ready;
  assign cmd_empty = (cmd_w == '0) || (cmd_h == '0);
  assign col_last  = (col_q == w_q - 1'b1);
  assign last_px   = col_last && (row_q == h_q - 1'b1);

  // col_q/row_q index the pixel currently on the outputs, so the walker
  // registers the *next* raster position each RUN cycle. On acceptance the
  // first pixel is produced straight from the request so it appears in the
  // cycle right after the handshake.
  logic [COORD_W-1:0]  ncol, nrow;
  logic [COORD_W-1:0]  base_x, base_y, off_x, off_y;
  logic [COLOUR_W-1:0] px_colour;
  logic [COORD_W:0]    ax, ay;
  logic                in_view;

  always_comb begin
    if (col_last) begin
      ncol = '0;
      nrow = row_q + 1'b1;
    end else begin
      ncol = col_q + 1'b1;
      nrow = row_q;
    end
  end

  always_comb begin
    if (state == S_RUN) begin
      base_x    = x0_q;
      base_y    = y0_q;
      off_x     = ncol;
      off_y     = nrow;
      px_colour = colour_q;
    end else begin
      base_x    = cmd_x0;
      base_y    = cmd_y0;
      off_x     = '0;
      off_y     = '0;
      px_colour = req_colour;
    end
    // One extra bit so x0+col never wraps back into the visible area
    ax      = {1'b0, base_x} + {1'b0, off_x};
    ay      = {1'b0, base_y} + {1'b0, off_y};
    in_view = (ax < LIM_X) && (ay < LIM_Y);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      colour_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            x0_q      <= cmd_x0;
            y0_q      <= cmd_y0;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            colour_q  <= req_colour;
            col_q     <= '0;
            row_q     <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_empty) begin
              state  <= S_DONE;
              done   <= 1'b1;
              plot   <= 1'b0;
              x      <= '0;
              y      <= '0;
              colour <= '0;
            end else begin
              state  <= S_RUN;
              plot   <= in_view;
              x      <= in_view ? ax[COORD_W-1:0] : '0;
              y      <= in_view ? ay[COORD_W-1:0] : '0;
              colour <= in_view ? px_colour : '0;
            end
          end
        end

        S_RUN: begin
          if (last_px) begin
            state  <= S_DONE;
            done   <= 1'b1;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
          end else begin
            col_q  <= ncol;
            row_q  <= nrow;
            plot   <= in_view;
            x      <= in_view ? ax[COORD_W-1:0] : '0;
            y      <= in_view ? ay[COORD_W-1:0] : '0;
            colour <= in_view ? px_colour : '0;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          plot      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          plot      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter
//   Directed bench for rect_plotter: reset, on-screen fill, clipping,
//   full-screen clear, empty command, backpressure and mid-command reset.
`timescale 1ns/1ps
module tb_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x0, req_y0, req_w, req_h;
  logic [2:0] req_colour;
  logic       req_clear;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic       plot, busy, done;

  always #10 CLOCK_50 = ~CLOCK_50;

  rect_plotter #(
    .SCREEN_W (160),
    .SCREEN_H (120),
    .COORD_W  (8),
    .COLOUR_W (3)
  ) dut (
    .clock      (CLOCK_50),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x0     (req_x0),
    .req_y0     (req_y0),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .req_clear  (req_clear),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the engine idle; returns at the falling
  // edge of the first cycle after the accepting edge.
  task automatic issue(input int x0, input int y0, input int w, input int h,
                       input int col, input bit clr);
    req_x0     = 8'(x0);
    req_y0     = 8'(y0);
    req_w      = 8'(w);
    req_h      = 8'(h);
    req_colour = 3'(col);
    req_clear  = clr;
    req_valid  = 1'b1;
    check_eq("ready_at_issue", req_ready, 1);
    @(negedge CLOCK_50);
    req_valid  = 1'b0;
    req_x0     = 8'hA5;
    req_y0     = 8'h5A;
    req_w      = 8'h33;
    req_h      = 8'h44;
    req_colour = 3'b010;
    req_clear  = 1'b0;
  endtask

  int got_plots, got_done, px_err;
  int first_x, first_y, last_x, last_y, max_x, max_y;

  // Walks the output stream cycle by cycle against the expected raster.
  // Cycle i=1 is the first cycle after acceptance.
  task automatic collect(input int x0, input int y0, input int w, input int h,
                         input int col, input int budget);
    int n;
    n = w * h;
    got_plots = 0; got_done = 0; px_err = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; max_x = 0; max_y = 0;
    for (int i = 1; i <= budget; i++) begin
      int ex_plot, ex_x, ex_y, ex_c, ax, ay;
      ex_plot = 0; ex_x = 0; ex_y = 0; ex_c = 0;
      if (i <= n) begin
        ax = x0 + (i - 1) % w;
        ay = y0 + (i - 1) / w;
        if (ax < 160 && ay < 120) begin
          ex_plot = 1; ex_x = ax; ex_y = ay; ex_c = col;
        end
        if (busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0) px_err++;
      end
      if (plot !== 1'(ex_plot) || x !== 8'(ex_x) || y !== 8'(ex_y) || colour !== 3'(ex_c))
        px_err++;
      if (plot === 1'b1) begin
        got_plots++;
        if (first_x < 0) begin first_x = int'(x); first_y = int'(y); end
        last_x = int'(x); last_y = int'(y);
        if (int'(x) > max_x) max_x = int'(x);
        if (int'(y) > max_y) max_y = int'(y);
      end
      if (done === 1'b1) begin
        got_done = i;
        break;
      end
      @(negedge CLOCK_50);
    end
  endtask

  // At the done cycle: check it, then step to the next cycle and check idle.
  task automatic post_done(input string tag);
    check_eq({tag, "_busy_at_done"}, busy, 1);
    check_eq({tag, "_plot_at_done"}, plot, 0);
    check_eq({tag, "_ready_at_done"}, req_ready, 0);
    @(negedge CLOCK_50);
    check_eq({tag, "_ready_after"}, req_ready, 1);
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_done_after"}, done, 0);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pc, dc;
    resetn = 1'b0; req_valid = 1'b0; req_x0 = '0; req_y0 = '0;
    req_w = '0; req_h = '0; req_colour = '0; req_clear = 1'b0;

    // T1 reset
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check_eq("T1_ready", req_ready, 1);
    check_eq("T1_plot", plot, 0);
    check_eq("T1_busy", busy, 0);
    check_eq("T1_done", done, 0);
    check_eq("T1_x", x, 0);
    check_eq("T1_y", y, 0);
    check_eq("T1_colour", colour, 0);

    // T2 paddle
    issue(30, 100, 16, 2, 7, 1'b0);
    collect(30, 100, 16, 2, 7, 100);
    check_eq("T2_plots", got_plots, 32);
    check_eq("T2_done_cycle", got_done, 33);
    check_eq("T2_raster", px_err, 0);
    check_eq("T2_first_x", first_x, 30);
    check_eq("T2_first_y", first_y, 100);
    check_eq("T2_last_x", last_x, 45);
    check_eq("T2_last_y", last_y, 101);
    post_done("T2");

    // T3 clipping at right and bottom edges
    issue(150, 118, 16, 4, 6, 1'b0);
    collect(150, 118, 16, 4, 6, 100);
    check_eq("T3_plots", got_plots, 20);
    check_eq("T3_done_cycle", got_done, 65);
    check_eq("T3_raster", px_err, 0);
    check_eq("T3_max_x", max_x, 159);
    check_eq("T3_max_y", max_y, 119);
    check_eq("T3_first_x", first_x, 150);
    check_eq("T3_last_y", last_y, 119);
    post_done("T3");

    // T4 full-screen clear, geometry inputs are junk and must be ignored
    issue(77, 5, 3, 3, 0, 1'b1);
    collect(0, 0, 160, 120, 0, 19300);
    check_eq("T4_plots", got_plots, 19200);
    check_eq("T4_done_cycle", got_done, 19201);
    check_eq("T4_raster", px_err, 0);
    check_eq("T4_first_x", first_x, 0);
    check_eq("T4_first_y", first_y, 0);
    check_eq("T4_last_x", last_x, 159);
    check_eq("T4_last_y", last_y, 119);
    post_done("T4");

    // T5 empty command
    issue(20, 20, 0, 5, 5, 1'b0);
    collect(20, 20, 0, 5, 5, 10);
    check_eq("T5_empty_plots", got_plots, 0);
    check_eq("T5_empty_done_cycle", got_done, 1);
    post_done("T5_empty");

    // T5 backpressure: command A running, command B held valid mid-RUN
    issue(10, 10, 4, 1, 2, 1'b0);            // cycle 1
    check_eq("T5_A0_plot", plot, 1);
    check_eq("T5_A0_x", x, 10);
    @(negedge CLOCK_50);                     // cycle 2
    req_valid = 1'b1; req_x0 = 8'd50; req_y0 = 8'd60;
    req_w = 8'd2; req_h = 8'd1; req_colour = 3'd5; req_clear = 1'b0;
    check_eq("T5_ready_midrun", req_ready, 0);
    check_eq("T5_A1_x", x, 11);
    @(negedge CLOCK_50);                     // cycle 3
    check_eq("T5_A2_x", x, 12);
    check_eq("T5_A2_y", y, 10);
    check_eq("T5_A2_colour", colour, 2);
    @(negedge CLOCK_50);                     // cycle 4
    check_eq("T5_A3_x", x, 13);
    @(negedge CLOCK_50);                     // cycle 5
    check_eq("T5_A_done", done, 1);
    check_eq("T5_A_ready_at_done", req_ready, 0);
    @(negedge CLOCK_50);                     // cycle 6
    check_eq("T5_ready_c6", req_ready, 1);
    check_eq("T5_plot_c6", plot, 0);
    @(negedge CLOCK_50);                     // cycle 7: B accepted at previous edge
    req_valid = 1'b0;
    check_eq("T5_B0_plot", plot, 1);
    check_eq("T5_B0_x", x, 50);
    check_eq("T5_B0_y", y, 60);
    check_eq("T5_B0_colour", colour, 5);
    @(negedge CLOCK_50);                     // cycle 8
    check_eq("T5_B1_x", x, 51);
    @(negedge CLOCK_50);                     // cycle 9
    check_eq("T5_B_done", done, 1);
    @(negedge CLOCK_50);                     // cycle 10
    check_eq("T5_B_ready_after", req_ready, 1);
    @(negedge CLOCK_50);                     // cycle 11: nothing re-accepted
    check_eq("T5_idle_busy", busy, 0);
    check_eq("T5_idle_plot", plot, 0);

    // T6 reset mid-RUN
    issue(40, 40, 8, 8, 3, 1'b0);            // cycle 1
    for (int k = 0; k < 5; k++) begin
      check_eq("T6_pre_plot", plot, 1);
      check_eq("T6_pre_x", x, 40 + k);
      if (k < 4) @(negedge CLOCK_50);
    end
    resetn = 1'b0;
    @(negedge CLOCK_50);
    check_eq("T6_abort_plot", plot, 0);
    check_eq("T6_abort_done", done, 0);
    check_eq("T6_abort_busy", busy, 0);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check_eq("T6_ready_after", req_ready, 1);
    pc = 0; dc = 0;
    for (int k = 0; k < 70; k++) begin
      if (plot !== 1'b0) pc++;
      if (done !== 1'b0) dc++;
      @(negedge CLOCK_50);
    end
    check_eq("T6_no_plots", pc, 0);
    check_eq("T6_no_done", dc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
